// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic feeder and the systolic array it drives.
// Holds the feeder state encoding and the default array geometry / timeout.
package systolic_pkg;

  localparam int N_DEF       = 3;   // array dimension
  localparam int DW_DEF      = 8;   // operand width
  localparam int CW_DEF      = 16;  // result element width
  localparam int TIMEOUT_DEF = 16;  // maximum WAIT cycles before giving up

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_WAIT  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/systolic_feeder.sv
// Systolic array feeder.
// Accepts one matrix pair (A, B), clears the array accumulators, streams
// column k of A and row k of B for k = 0..N-1, flushes with zeros, then waits
// for the array result, captures it and offers it downstream.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operand pair handshake (accepted when both high)
//   mat_a, mat_b      N*N*DW packed matrices, element (r,c) at [(r*N+c)*DW +: DW]
//   arr_clr_n         active-low accumulator clear to the array (one cycle)
//   arr_a             A column stream, row r at [r*DW +: DW]
//   arr_b             B row stream, column c at [c*DW +: DW]
//   arr_c, arr_valid  array result and its valid strobe (honoured in WAIT only)
//   res_c             captured result, element (r,c) at [(r*N+c)*CW +: CW]
//   res_valid/res_ready result handshake (transfer when both high)
//   timeout           one-cycle pulse when WAIT expires without a result
//   dbg_state         current FSM state, for observation
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; valid/ready are not withdrawn by this block before the transfer,
// and in_valid offered while in_ready is low is simply dropped.
//
// Every output is a register loaded from the next-state decode, so outputs
// reflect the state being entered at each edge.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DW      = DW_DEF,
  parameter int CW      = CW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*DW-1:0] mat_a,
  input  logic [N*N*DW-1:0] mat_b,
  output logic              arr_clr_n,
  output logic [N*DW-1:0]   arr_a,
  output logic [N*DW-1:0]   arr_b,
  input  logic [N*N*CW-1:0] arr_c,
  input  logic              arr_valid,
  output logic [N*N*CW-1:0] res_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              timeout,
  output state_t            dbg_state
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_END  = TW'(TIMEOUT);

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [TW-1:0]       r_wcnt;
  logic [N*N*DW-1:0]   r_mat_a;
  logic [N*N*DW-1:0]   r_mat_b;
  logic                r_in_ready;
  logic                r_arr_clr_n;
  logic [N*DW-1:0]     r_arr_a;
  logic [N*DW-1:0]     r_arr_b;
  logic [N*N*CW-1:0]   r_res_c;
  logic                r_res_valid;
  logic                r_timeout;

  state_t              w_state_nxt;
  logic [KW-1:0]       w_k_nxt;
  logic [TW-1:0]       w_wcnt_nxt;
  logic                w_load_mat;
  logic                w_load_res;
  logic                w_timeout_nxt;
  logic [N*DW-1:0]     w_arr_a_nxt;
  logic [N*DW-1:0]     w_arr_b_nxt;

  // Next-state and control decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_wcnt_nxt    = r_wcnt;
    w_load_mat    = 1'b0;
    w_load_res    = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_state_nxt = S_CLEAR;
          w_load_mat  = 1'b1;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_FEED;
        w_k_nxt     = '0;
      end
      S_FEED: begin
        if (r_k == K_LAST) begin
          w_state_nxt = S_FLUSH;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_WAIT;
        w_wcnt_nxt  = '0;
      end
      S_WAIT: begin
        // The count parks at TIMEOUT for the single cycle the timeout pulse
        // is visible; the state then returns to IDLE without touching res_c.
        if (r_wcnt == T_END) begin
          w_state_nxt = S_IDLE;
        end else if (arr_valid) begin
          w_state_nxt = S_HOLD;
          w_load_res  = 1'b1;
        end else begin
          w_wcnt_nxt    = r_wcnt + 1'b1;
          w_timeout_nxt = (r_wcnt == T_LAST);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand selection for the cycle being entered: zeros unless feeding.
  always_comb begin
    w_arr_a_nxt = '0;
    w_arr_b_nxt = '0;
    if (w_state_nxt == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        w_arr_a_nxt[i*DW +: DW] = r_mat_a[(i*N + int'(w_k_nxt))*DW +: DW];
        w_arr_b_nxt[i*DW +: DW] = r_mat_b[(int'(w_k_nxt)*N + i)*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_wcnt      <= '0;
      r_mat_a     <= '0;
      r_mat_b     <= '0;
      r_in_ready  <= 1'b0;
      r_arr_clr_n <= 1'b1;
      r_arr_a     <= '0;
      r_arr_b     <= '0;
      r_res_c     <= '0;
      r_res_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_arr_clr_n <= (w_state_nxt != S_CLEAR);
      r_arr_a     <= w_arr_a_nxt;
      r_arr_b     <= w_arr_b_nxt;
      r_res_valid <= (w_state_nxt == S_HOLD);
      r_timeout   <= w_timeout_nxt;
      if (w_load_mat) begin
        r_mat_a <= mat_a;
        r_mat_b <= mat_b;
      end
      if (w_load_res) begin
        r_res_c <= arr_c;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign arr_clr_n = r_arr_clr_n;
  assign arr_a     = r_arr_a;
  assign arr_b     = r_arr_b;
  assign res_c     = r_res_c;
  assign res_valid = r_res_valid;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural accumulating array.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int TO = 16;

  localparam logic [N*N*DW-1:0] MAT_A  = 72'h090807060504030201;
  localparam logic [N*N*DW-1:0] MAT_B  = 72'h010203040506070809;
  localparam logic [N*N*CW-1:0] RES_AA = {16'd150, 16'd126, 16'd102, 16'd96, 16'd81,
                                          16'd66, 16'd42, 16'd36, 16'd30};
  localparam logic [N*N*CW-1:0] RES_AB = {16'd90, 16'd114, 16'd138, 16'd54, 16'd69,
                                          16'd84, 16'd18, 16'd24, 16'd30};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*N*DW-1:0] mat_a = '0;
  logic [N*N*DW-1:0] mat_b = '0;
  logic              arr_clr_n;
  logic [N*DW-1:0]   arr_a;
  logic [N*DW-1:0]   arr_b;
  logic [N*N*CW-1:0] arr_c;
  logic              arr_valid = 1'b0;
  logic [N*N*CW-1:0] res_c;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              timeout;
  state_t            dbg_state;

  systolic_feeder #(.N(N), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .arr_clr_n (arr_clr_n),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .arr_c     (arr_c),
    .arr_valid (arr_valid),
    .res_c     (res_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- array model ----------------
  logic [CW-1:0]     acc [N][N];
  logic [N*N*CW-1:0] arr_c_model;
  logic [N*N*CW-1:0] junk = '0;
  logic              use_junk = 1'b0;

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!arr_clr_n || !rst) acc[r][c] <= '0;
        else acc[r][c] <= acc[r][c] + CW'(arr_a[r*DW +: DW]) * CW'(arr_b[c*DW +: DW]);
      end
    end
  end

  always_comb begin
    arr_c_model = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        arr_c_model[(r*N+c)*CW +: CW] = acc[r][c];
  end

  assign arr_c = use_junk ? junk : arr_c_model;

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
    mat_a    = a;
    mat_b    = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_clr_n", arr_clr_n, 1'b1);
    chk("rst_arr_a", arr_a, '0);
    chk("rst_arr_b", arr_b, '0);
    chk("rst_res_c", res_c, '0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_state", dbg_state, S_IDLE);
    rst = 1'b1;
    tick();
    chk("ready_after_rst", in_ready, 1'b1);

    // Scenario 1: A*A, minimum latency
    accept(MAT_A, MAT_A);
    chk("s1_state_clear", dbg_state, S_CLEAR);
    chk("s1_clr_n_low", arr_clr_n, 1'b0);
    chk("s1_in_ready_busy", in_ready, 1'b0);
    chk("s1_clear_a_zero", arr_a, '0);
    tick();
    chk("s1_f0_a", arr_a, 24'h070401);
    chk("s1_f0_b", arr_b, 24'h030201);
    chk("s1_f0_clr_n", arr_clr_n, 1'b1);
    tick();
    chk("s1_f1_a", arr_a, 24'h080502);
    chk("s1_f1_b", arr_b, 24'h060504);
    tick();
    chk("s1_f2_a", arr_a, 24'h090603);
    chk("s1_f2_b", arr_b, 24'h090807);
    tick();
    chk("s1_flush_state", dbg_state, S_FLUSH);
    chk("s1_flush_a", arr_a, '0);
    chk("s1_flush_b", arr_b, '0);
    tick();
    chk("s1_wait_state", dbg_state, S_WAIT);
    chk("s1_wait_noval", res_valid, 1'b0);
    arr_valid = 1'b1;
    tick();
    arr_valid = 1'b0;
    chk("s1_res_valid", res_valid, 1'b1);
    chk("s1_res_c", res_c, RES_AA);
    chk("s1_hold_state", dbg_state, S_HOLD);

    // Scenario 2: back-to-back pair, res_ready already high in HOLD
    res_ready = 1'b1;
    mat_b     = MAT_B;
    in_valid  = 1'b1;
    tick();
    chk("s2_released", res_valid, 1'b0);
    chk("s2_ready", in_ready, 1'b1);
    chk("s2_idle_clr_n", arr_clr_n, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("s2_clr_n_low", arr_clr_n, 1'b0);
    tick();
    chk("s2_f0_clr_n", arr_clr_n, 1'b1);
    chk("s2_f0_a", arr_a, 24'h070401);
    chk("s2_f0_b", arr_b, 24'h070809);
    tick();
    chk("s2_f1_b", arr_b, 24'h040506);
    tick();
    chk("s2_f2_b", arr_b, 24'h010203);
    tick();
    tick();
    chk("s2_wait_state", dbg_state, S_WAIT);
    arr_valid = 1'b1;
    tick();
    arr_valid = 1'b0;
    chk("s2_res_valid", res_valid, 1'b1);
    chk("s2_res_c", res_c, RES_AB);
    tick();
    chk("s2_first_cycle_xfer", res_valid, 1'b0);
    chk("s2_back_idle", in_ready, 1'b1);
    res_ready = 1'b0;

    // Scenario 3: no arr_valid -> timeout 16 cycles after WAIT entry
    accept(MAT_A, MAT_A);
    repeat (5) tick();
    chk("s3_wait_entry", dbg_state, S_WAIT);
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("s3_no_early_timeout", timeout, 1'b0);
    end
    tick();
    chk("s3_timeout_pulse", timeout, 1'b1);
    chk("s3_ready_low_at_pulse", in_ready, 1'b0);
    chk("s3_no_res_valid", res_valid, 1'b0);
    chk("s3_res_c_kept", res_c, RES_AB);
    tick();
    chk("s3_timeout_one_cycle", timeout, 1'b0);
    chk("s3_ready_next", in_ready, 1'b1);
    chk("s3_no_res_valid2", res_valid, 1'b0);

    // Scenario 4: HOLD stall with changing arr_c and in_valid high
    accept(MAT_A, MAT_B);
    repeat (5) tick();
    arr_valid = 1'b1;
    tick();
    chk("s4_res_c", res_c, RES_AB);
    use_junk = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < N*N; j++) junk[j*CW +: CW] = CW'($urandom_range(0, 65535));
      tick();
      chk("s4_res_c_stable", res_c, RES_AB);
      chk("s4_in_ready_low", in_ready, 1'b0);
      chk("s4_res_valid_held", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    in_valid  = 1'b0;
    arr_valid = 1'b0;
    use_junk  = 1'b0;
    tick();
    res_ready = 1'b0;
    chk("s4_xfer_done", res_valid, 1'b0);
    chk("s4_idle", dbg_state, S_IDLE);
    chk("s4_res_c_after", res_c, RES_AB);

    // Scenario 5: reset pulse during FEED k=1
    accept(MAT_A, MAT_A);
    tick();
    tick();
    chk("s5_in_feed", arr_a, 24'h080502);
    #2 rst = 1'b0;
    #1;
    chk("s5_async_state", dbg_state, S_IDLE);
    chk("s5_async_arr_a", arr_a, '0);
    chk("s5_async_arr_b", arr_b, '0);
    chk("s5_async_clr_n", arr_clr_n, 1'b1);
    chk("s5_async_res_c", res_c, '0);
    chk("s5_async_ready", in_ready, 1'b0);
    chk("s5_async_valid", res_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("s5_ready_after", in_ready, 1'b1);
    chk("s5_no_timeout", timeout, 1'b0);

    // Scenario 6: stray arr_valid during FEED, then correct result
    accept(MAT_A, MAT_B);
    tick();
    arr_valid = 1'b1;
    tick();
    arr_valid = 1'b0;
    chk("s6_stray_state", dbg_state, S_FEED);
    chk("s6_stray_valid", res_valid, 1'b0);
    chk("s6_stray_res_c", res_c, '0);
    tick();
    tick();
    tick();
    chk("s6_wait_state", dbg_state, S_WAIT);
    arr_valid = 1'b1;
    tick();
    arr_valid = 1'b0;
    chk("s6_res_valid", res_valid, 1'b1);
    chk("s6_res_c", res_c, RES_AB);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("s6_done", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameters: N, default 3, array dimension; DW, default 8, operand width; CW, default 16, result element width; TIMEOUT, default 16, maximum WAIT cycles.
REQ-002 SHALL use one clock and an asynchronous active-low reset. Ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  operand pair offered; in_ready  out  1  feeder can accept.
REQ-004 SHALL have ports: mat_a  in  N*N*DW  matrix A, element (r,c) at [(r*N+c)*DW +: DW]; mat_b  in  N*N*DW  matrix B, same packing.
REQ-005 SHALL have ports: arr_clr_n  out  1  active-low accumulator clear to array; arr_a  out  N*DW  A column stream, row r at [r*DW +: DW]; arr_b  out  N*DW  B row stream, column c at [c*DW +: DW].
REQ-006 SHALL have ports: arr_c  in  N*N*CW  array result; arr_valid  in  1  array result valid.
REQ-007 SHALL have ports: res_c  out  N*N*CW  captured result, element (r,c) at [(r*N+c)*CW +: CW]; res_valid  out  1  result offered; res_ready  in  1  result taken; timeout  out  1  one-cycle pulse on WAIT expiry.

Function
REQ-008 SHALL implement states IDLE, CLEAR, FEED, FLUSH, WAIT, HOLD.
REQ-009 IDLE: SHALL hold in_ready=1; on in_valid&&in_ready SHALL register mat_a and mat_b and go to CLEAR. in_ready SHALL be 0 in every other state.
REQ-010 CLEAR: SHALL drive arr_clr_n=0 for exactly one cycle, with arr_a=arr_b=0, then go to FEED with k=0.
REQ-011 FEED: SHALL last N cycles. In cycle k: arr_a[r]=A(r,k) and arr_b[c]=B(k,c). After k=N-1, SHALL go to FLUSH.
REQ-012 FLUSH: SHALL drive arr_a=arr_b=0 for one cycle, then go to WAIT. Zeros SHALL be held in all states except FEED.
REQ-013 WAIT: SHALL count cycles from 0. When arr_valid=1, SHALL register arr_c into res_c and go to HOLD. If the count reaches TIMEOUT without arr_valid, SHALL pulse timeout for one cycle and go to IDLE with res_c unchanged.
REQ-014 HOLD: SHALL assert res_valid with res_c stable. When res_ready=1, SHALL go to IDLE. A res_ready already high on the first HOLD cycle SHALL complete the transfer on that cycle.
REQ-015 arr_valid outside WAIT SHALL be ignored. in_valid while in_ready=0 SHALL be ignored and not queued.
REQ-016 Minimum latency from accept edge to res_valid SHALL be N+3 cycles: CLEAR 1, FEED N, FLUSH 1, WAIT ≥1.
REQ-017 All outputs SHALL be registered. No arithmetic beyond the WAIT counter (width clog2(TIMEOUT+1)) and the FEED index (clog2(N)).

Reset
REQ-018 While rst=0, regardless of state, SHALL force: state=IDLE, in_ready=0, arr_clr_n=1, arr_a=arr_b=0, res_c=0, res_valid=0, timeout=0, counters=0.
REQ-019 in_ready SHALL rise on the first clk edge after rst deasserts.
REQ-020 Reset mid-operation SHALL abandon the in-flight matrices with no result and no timeout pulse.

Structure
REQ-021 Package systolic_pkg SHALL hold the state enum, the N/DW/CW defaults and the TIMEOUT default. The existing array SHALL share this package.
REQ-022 The feeder SHALL be a single module with no sub-modules. The WAIT counter SHALL be inline.

Verification
REQ-023 Scenario: A=B=[[1,2,3],[4,5,6],[7,8,9]] with an array model. Required: arr_a/arr_b = 070401/030201, 080502/060504, 090603/090807 (hex) on consecutive FEED cycles; res_c = 30,36,42,66,81,96,102,126,150.
REQ-024 Scenario: back-to-back second pair A as REQ-023, B=[[9,8,7],[6,5,4],[3,2,1]]. Required: arr_clr_n low one cycle before the first FEED; res_c = 30,24,18,84,69,54,138,114,90.
REQ-025 Scenario: array model never asserts arr_valid. Required: timeout high exactly one cycle, 16 cycles after WAIT entry; in_ready=1 on the next cycle; res_valid never asserted.
REQ-026 Scenario: res_ready held low for 5 cycles in HOLD, with arr_c changing and in_valid=1. Required: res_c stable; in_ready=0; the transfer completes on the first res_ready=1 cycle.
REQ-027 Scenario: rst pulsed low during FEED k=1. Required: all outputs at their reset values asynchronously; no res_valid; the next accepted pair produces a correct result.
REQ-028 Scenario: stray arr_valid during FEED. Required: ignored, and res_c equals the correct product on the later arr_valid.
